// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings, bridge state type and the byte-strobe helper.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // ERR1/ERR2 are the two cycles of the AHB ERROR response.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

  // Byte lanes touched by a 32-bit AHB write; sizes above a word act as a word.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_apb_rsp_mux.sv
// Picks the response of the currently addressed APB slave; all other slaves'
// ready/error/data lines are invisible to the bridge.
module ahb_apb_rsp_mux
  import ahb_apb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSLV   = 4,
  parameter int SELW   = 2
) (
  input  logic [SELW-1:0]        idx,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  output logic                   slverr
);

  // Select the slave whose index matches the registered slave index.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path can leave a latch.
    rdata  = '0;
    ready  = 1'b0;
    slverr = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == SELW'(i)) begin
        rdata  = prdata[i*DATA_W +: DATA_W];
        ready  = pready[i];
        slverr = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// Multi-slave AHB-to-APB bridge: one-hot slave decode, APB wait states,
// slave/decode/timeout errors returned as a two-cycle AHB ERROR.
module ahb_apb_bridge_mc
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 256
) (
  input  logic                   Hclk,
  input  logic                   Hreset,
  input  logic                   Hsel,
  input  logic                   Hwrite,
  input  logic                   Hreadyin,
  input  logic [1:0]             Htrans,
  input  logic [2:0]             Hsize,
  input  logic [ADDR_W-1:0]      Haddr,
  input  logic [DATA_W-1:0]      Hwdata,
  output logic                   Hreadyout,
  output logic [1:0]             Hresp,
  output logic [DATA_W-1:0]      Hrdata,
  output logic [NSLV-1:0]        Pselx,
  output logic                   Penable,
  output logic                   Pwrite,
  output logic [ADDR_W-1:0]      Paddr,
  output logic [DATA_W-1:0]      Pwdata,
  output logic [DATA_W/8-1:0]    Pstrb,
  input  logic [NSLV*DATA_W-1:0] Prdata,
  input  logic [NSLV-1:0]        Pready,
  input  logic [NSLV-1:0]        Pslverr
);

  localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [SELW-1:0]     idx_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic                pwrite_q;
  logic [DATA_W/8-1:0] pstrb_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W-1:0]   hrdata_q;
  logic [CNTW-1:0]     cnt_q;

  logic [SELW-1:0]     haddr_idx;
  logic                idx_ok;
  logic                accept;
  logic                apb_active;
  logic                timeout_hit;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;
  logic                sel_slverr;

  assign haddr_idx = Haddr[SEL_LSB +: SELW];
  // Non-power-of-two slave counts leave index codes with no slave behind them.
  assign idx_ok    = 32'(haddr_idx) < NSLV;
  assign accept    = Hsel && Hreadyin &&
                     (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ) &&
                     (state_q == IDLE || state_q == ERR2);
  assign apb_active = (state_q == SETUP) || (state_q == ACCESS);

  // Abort only while the slave is still stalling on its last allowed cycle.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !sel_ready &&
                       (cnt_q == CNT_LAST);

  ahb_apb_rsp_mux #(
    .DATA_W (DATA_W),
    .NSLV   (NSLV),
    .SELW   (SELW)
  ) u_rsp_mux (
    .idx     (idx_q),
    .prdata  (Prdata),
    .pready  (Pready),
    .pslverr (Pslverr),
    .rdata   (sel_rdata),
    .ready   (sel_ready),
    .slverr  (sel_slverr)
  );

  // State register; reset returns the bridge to IDLE and drops APB selects at once.
  always_ff @(posedge Hclk or posedge Hreset) begin
    // NOTE: registered state is always updated with <= so all flops see pre-edge values.
    if (Hreset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and AHB-side handshake outputs decoded from the state.
  always_comb begin
    state_d   = state_q;
    Hreadyout = 1'b1;
    Hresp     = HRESP_OKAY;
    Penable   = 1'b0;
    case (state_q)
      IDLE, ERR2: begin
        if (state_q == ERR2) Hresp = HRESP_ERROR;
        if (accept) state_d = idx_ok ? SETUP : ERR1;
        else        state_d = IDLE;
      end
      SETUP: begin
        Hreadyout = 1'b0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        Hreadyout = 1'b0;
        Penable   = 1'b1;
        if (timeout_hit)    state_d = ERR1;
        else if (sel_ready) state_d = sel_slverr ? ERR1 : IDLE;
      end
      ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = HRESP_ERROR;
        state_d   = ERR2;
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot slave select, held through SETUP and ACCESS.
  always_comb begin
    Pselx = '0;
    for (int i = 0; i < NSLV; i++) begin
      Pselx[i] = apb_active && (idx_q == SELW'(i));
    end
  end

  // Address/control capture at accept, write data at SETUP exit, read data on good completion.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      idx_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (accept) begin
        idx_q    <= haddr_idx;
        paddr_q  <= Haddr;
        pwrite_q <= Hwrite;
        pstrb_q  <= Hwrite ? byte_strobe(Hsize, Haddr[1:0]) : '0;
      end
      if (state_q == SETUP) pwdata_q <= Hwdata;
      if (state_q == ACCESS && sel_ready && !sel_slverr && !pwrite_q)
        hrdata_q <= sel_rdata;
    end
  end

  // Wait-state counter: restarts in SETUP, counts ACCESS cycles with the slave stalling.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset)                           cnt_q <= '0;
    else if (state_q == SETUP)            cnt_q <= '0;
    else if (state_q == ACCESS && !sel_ready) cnt_q <= cnt_q + CNTW'(1);
  end

  // Write data is live from the bus during SETUP and held from the register afterwards.
  assign Pwdata = (state_q == SETUP) ? Hwdata : pwdata_q;
  assign Paddr  = paddr_q;
  assign Pwrite = pwrite_q;
  assign Pstrb  = pstrb_q;
  assign Hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// Self-checking bench: transaction-level timeline model of the bridge,
// randomized transfers with random APB wait states and errors.
module tb_ahb_apb_bridge_mc;
  import ahb_apb_pkg::*;

  localparam int NSLV    = 3;
  localparam int TIMEOUT = 4;
  localparam int SEL_LSB = 12;
  localparam int DW      = 32;
  localparam int AW      = 32;

  logic              Hclk = 1'b0;
  logic              Hreset, Hsel, Hwrite, Hreadyin;
  logic [1:0]        Htrans;
  logic [2:0]        Hsize;
  logic [AW-1:0]     Haddr;
  logic [DW-1:0]     Hwdata;
  logic              Hreadyout;
  logic [1:0]        Hresp;
  logic [DW-1:0]     Hrdata;
  logic [NSLV-1:0]   Pselx;
  logic              Penable, Pwrite;
  logic [AW-1:0]     Paddr;
  logic [DW-1:0]     Pwdata;
  logic [DW/8-1:0]   Pstrb;
  logic [NSLV*DW-1:0] Prdata;
  logic [NSLV-1:0]   Pready, Pslverr;

  ahb_apb_bridge_mc #(
    .ADDR_W (AW), .DATA_W (DW), .NSLV (NSLV), .SEL_LSB (SEL_LSB), .TIMEOUT (TIMEOUT)
  ) dut (
    .Hclk (Hclk), .Hreset (Hreset), .Hsel (Hsel), .Hwrite (Hwrite), .Hreadyin (Hreadyin),
    .Htrans (Htrans), .Hsize (Hsize), .Haddr (Haddr), .Hwdata (Hwdata),
    .Hreadyout (Hreadyout), .Hresp (Hresp), .Hrdata (Hrdata),
    .Pselx (Pselx), .Penable (Penable), .Pwrite (Pwrite), .Paddr (Paddr),
    .Pwdata (Pwdata), .Pstrb (Pstrb), .Prdata (Prdata), .Pready (Pready), .Pslverr (Pslverr)
  );

  always #5 Hclk = ~Hclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the current cycle, maintained by the transaction model.
  logic            exp_ready, exp_pen, exp_pwrite;
  logic [1:0]      exp_resp;
  logic [DW-1:0]   exp_rdata, exp_pwdata;
  logic [AW-1:0]   exp_paddr;
  logic [NSLV-1:0] exp_psel;
  logic [3:0]      exp_pstrb;
  bit              chk_en = 0, chk_apb = 0, chk_pwd = 0;

  // Observations of the APB side used by the hand-computed expectations.
  logic [NSLV-1:0] mon_pselx = '0;
  logic [3:0]      mon_strb  = '0;
  int              mon_access = 0;
  int              mon_apb_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every enabled cycle, mid-period.
  always @(negedge Hclk) begin
    if (chk_en) begin
      check("hreadyout", 32'(Hreadyout), 32'(exp_ready));
      check("hresp",     32'(Hresp),     32'(exp_resp));
      check("hrdata",    Hrdata,         exp_rdata);
      check("pselx",     32'(Pselx),     32'(exp_psel));
      check("penable",   32'(Penable),   32'(exp_pen));
      if (chk_apb) begin
        check("paddr",  Paddr,        exp_paddr);
        check("pwrite", 32'(Pwrite),  32'(exp_pwrite));
        check("pstrb",  32'(Pstrb),   32'(exp_pstrb));
        if (chk_pwd) check("pwdata", Pwdata, exp_pwdata);
      end
    end
  end

  // APB-side monitor.
  always @(negedge Hclk) begin
    if (Pselx != '0 && !Penable) begin
      mon_pselx  = Pselx;
      mon_strb   = Pstrb;
      mon_access = 0;
    end
    if (Penable) mon_access++;
    if (Pselx != '0) mon_apb_cycles++;
  end

  // Byte lanes covered by an aligned access of 1, 2 or 4 bytes.
  function automatic logic [3:0] model_strb(input logic wr, input logic [2:0] sz,
                                            input logic [1:0] lo);
    int n, base;
    logic [3:0] s;
    s = '0;
    if (!wr) return s;
    n = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    base = (int'(lo) / n) * n;
    for (int b = 0; b < 4; b++) s[b] = (b >= base) && (b < base + n);
    return s;
  endfunction

  task automatic next_cycle();
    @(posedge Hclk);
    #1;
  endtask

  // sel < 0: every slave gets random (ignored) responses.
  task automatic drive_slaves(input int sel, input logic rdy, input logic err,
                              input logic [31:0] rd);
    for (int i = 0; i < NSLV; i++) begin
      if (i == sel) begin
        Pready[i] = rdy; Pslverr[i] = err; Prdata[i*DW +: DW] = rd;
      end else begin
        Pready[i] = 1'($urandom); Pslverr[i] = 1'($urandom); Prdata[i*DW +: DW] = $urandom;
      end
    end
  endtask

  // AHB inputs that must not start a transfer.
  task automatic bus_quiet();
    Haddr = $urandom; Hwrite = 1'($urandom); Hsize = 3'($urandom); Hwdata = $urandom;
    Hreadyin = 1'b1;
    case ($urandom_range(0, 3))
      0: begin Hsel = 1'b0; Htrans = HTRANS_NONSEQ; end
      1: begin Hsel = 1'b1; Htrans = HTRANS_IDLE; end
      2: begin Hsel = 1'b1; Htrans = HTRANS_BUSY; end
      default: begin Hsel = 1'b1; Htrans = HTRANS_NONSEQ; Hreadyin = 1'b0; end
    endcase
  endtask

  // Arbitrary AHB inputs while the bridge is busy.
  task automatic bus_random();
    Hsel = 1'($urandom); Htrans = 2'($urandom); Hreadyin = 1'($urandom);
    Haddr = $urandom; Hwrite = 1'($urandom); Hsize = 3'($urandom);
  endtask

  task automatic idle_cycle();
    bus_quiet();
    drive_slaves(-1, 1'b0, 1'b0, 32'h0);
    next_cycle();
    exp_ready = 1'b1; exp_resp = HRESP_OKAY; exp_psel = '0; exp_pen = 1'b0;
    chk_apb = 0; chk_pwd = 0;
  endtask

  // One AHB transfer. Called at the start of a cycle where the bridge can accept;
  // returns at the start of the cycle in which Hreadyout is high again.
  // waits = number of ACCESS cycles the addressed slave holds Pready low.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wdata, input int waits, input logic err,
                      input logic [31:0] rd);
    int  idx;
    bit  ready_now, aborted;
    idx = int'(addr[SEL_LSB +: 2]);
    // address phase
    Hsel = 1'b1; Hreadyin = 1'b1;
    Htrans = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
    Haddr = addr; Hwrite = wr; Hsize = sz; Hwdata = $urandom;
    drive_slaves(-1, 1'b0, 1'b0, 32'h0);
    next_cycle();
    bus_random(); Hwdata = wdata;
    drive_slaves(-1, 1'b0, 1'b0, 32'h0);
    if (idx >= NSLV) begin
      exp_ready = 1'b0; exp_resp = HRESP_ERROR; exp_psel = '0; exp_pen = 1'b0;
      chk_apb = 0; chk_pwd = 0;
      next_cycle();
      bus_quiet(); drive_slaves(-1, 1'b0, 1'b0, 32'h0);
      exp_ready = 1'b1;
      return;
    end
    // SETUP cycle
    exp_ready = 1'b0; exp_resp = HRESP_OKAY; exp_psel = '0; exp_psel[idx] = 1'b1;
    exp_pen = 1'b0; chk_apb = 1; chk_pwd = 0;
    exp_paddr = addr; exp_pwrite = wr; exp_pstrb = model_strb(wr, sz, addr[1:0]);
    aborted = 0;
    for (int k = 0; k < 64; k++) begin
      next_cycle();
      bus_random(); Hwdata = $urandom;
      exp_pen = 1'b1; chk_pwd = wr; exp_pwdata = wdata;
      ready_now = (k >= waits);
      aborted   = !ready_now && (TIMEOUT != 0) && (k == TIMEOUT - 1);
      drive_slaves(idx, ready_now, ready_now ? err : 1'($urandom), ready_now ? rd : $urandom);
      if (ready_now || aborted) break;
    end
    next_cycle();
    exp_psel = '0; exp_pen = 1'b0; chk_apb = 0; chk_pwd = 0;
    if (aborted || err) begin
      bus_random(); drive_slaves(-1, 1'b0, 1'b0, 32'h0);
      exp_ready = 1'b0; exp_resp = HRESP_ERROR;
      next_cycle();
      exp_ready = 1'b1;
    end else begin
      exp_ready = 1'b1; exp_resp = HRESP_OKAY;
      if (!wr) exp_rdata = rd;
    end
    bus_quiet(); drive_slaves(-1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Hreset = 1'b1; Hsel = 1'b0; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = HTRANS_IDLE;
    Hsize = HSIZE_WORD; Haddr = '0; Hwdata = '0; Prdata = '0; Pready = '0; Pslverr = '0;
    exp_ready = 1'b1; exp_resp = HRESP_OKAY; exp_rdata = '0; exp_psel = '0; exp_pen = 1'b0;
    exp_pwrite = 1'b0; exp_paddr = '0; exp_pwdata = '0; exp_pstrb = '0;
    next_cycle(); next_cycle();
    Hreset = 1'b0;

    // reset values
    check("rst_hreadyout", 32'(Hreadyout), 32'h1);
    check("rst_hresp",     32'(Hresp),     32'h0);
    check("rst_hrdata",    Hrdata,         32'h0);
    check("rst_pselx",     32'(Pselx),     32'h0);
    check("rst_penable",   32'(Penable),   32'h0);
    check("rst_pwrite",    32'(Pwrite),    32'h0);
    check("rst_paddr",     Paddr,          32'h0);
    check("rst_pwdata",    Pwdata,         32'h0);
    check("rst_pstrb",     32'(Pstrb),     32'h0);
    chk_en = 1;
    idle_cycle(); idle_cycle();

    // word write to slave 2, zero wait
    xfer(32'h0000_2004, 1'b1, HSIZE_WORD, 32'hA5A5_1234, 0, 1'b0, 32'h0);
    check("lit_w2_pselx",  32'(mon_pselx), 32'h4);
    check("lit_w2_pstrb",  32'(mon_strb),  32'hF);
    check("lit_w2_access", 32'(mon_access), 32'd1);
    idle_cycle();

    // read slave 1 with three stall cycles (one short of the timeout)
    xfer(32'h0000_1000, 1'b0, HSIZE_WORD, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
    check("lit_r1_access", 32'(mon_access), 32'd4);
    check("lit_r1_hrdata", Hrdata, 32'hDEAD_BEEF);
    idle_cycle();

    // slave error
    xfer(32'h0000_0008, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b1, 32'h1357_9BDF);
    check("lit_slverr_hresp",  32'(Hresp),     32'h1);
    check("lit_slverr_hready", 32'(Hreadyout), 32'h1);
    check("lit_slverr_hrdata", Hrdata, 32'hDEAD_BEEF);
    idle_cycle();

    // decode error on an index with no slave
    mon_apb_cycles = 0;
    xfer(32'h0000_3000, 1'b1, HSIZE_WORD, 32'h1111_2222, 0, 1'b0, 32'h0);
    check("lit_decode_apb", 32'(mon_apb_cycles), 32'd0);
    check("lit_decode_hresp", 32'(Hresp), 32'h1);
    idle_cycle();

    // timeout with Pready stuck low
    xfer(32'h0000_0100, 1'b0, HSIZE_WORD, 32'h0, 50, 1'b0, 32'h0);
    check("lit_timeout_access", 32'(mon_access), 32'd4);
    idle_cycle();

    // byte write to the top byte lane
    xfer(32'h0000_2003, 1'b1, HSIZE_BYTE, 32'hCC00_0000, 1, 1'b0, 32'h0);
    check("lit_byte_pstrb", 32'(mon_strb), 32'h8);

    // back-to-back: half write then read with no idle cycle
    xfer(32'h0000_0002, 1'b1, HSIZE_HALF, 32'h00BB_0000, 0, 1'b0, 32'h0);
    check("lit_half_pstrb", 32'(mon_strb), 32'hC);
    xfer(32'h0000_1010, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h600D_F00D);
    idle_cycle();

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      a = $urandom;
      xfer(a, 1'($urandom), 3'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 6), ($urandom_range(0, 5) == 0), $urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end
    idle_cycle();

    // asynchronous reset in the middle of ACCESS
    chk_en = 0;
    Hsel = 1'b1; Hreadyin = 1'b1; Htrans = HTRANS_NONSEQ;
    Haddr = 32'h0000_0010; Hwrite = 1'b0; Hsize = HSIZE_WORD;
    drive_slaves(0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    bus_quiet(); drive_slaves(0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    check("lit_pre_rst_penable", 32'(Penable), 32'h1);
    #2 Hreset = 1'b1;
    #1;
    check("lit_arst_pselx",   32'(Pselx),     32'h0);
    check("lit_arst_penable", 32'(Penable),   32'h0);
    check("lit_arst_hready",  32'(Hreadyout), 32'h1);
    next_cycle();
    Hreset = 1'b0;
    exp_ready = 1'b1; exp_resp = HRESP_OKAY; exp_rdata = '0; exp_psel = '0; exp_pen = 1'b0;
    chk_apb = 0; chk_pwd = 0;
    chk_en = 1;
    idle_cycle();
    xfer(32'h0000_2000, 1'b0, HSIZE_WORD, 32'h0, 2, 1'b0, 32'h0BAD_CAFE);
    idle_cycle(); idle_cycle();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
